// File: rtl/anton_neopixel_sequencer_if.sv
// Control and status bundle between the register block and the NeoPixel sequencer.
// state: 1 = TRANSMIT, 0 = RESET (idle or latch period).
interface anton_neopixel_sequencer_if #(
  parameter int BUFFER_BITS = 8
);
  logic                   regCtrlRun;
  logic                   regCtrlLoop;
  logic                   regCtrl32bit;
  logic [BUFFER_BITS-1:0] regMax;
  logic                   state;
  logic [BUFFER_BITS-1:0] bufferAddr;
  logic [2:0]             pixelBitIndex;
  logic [1:0]             channelIndex;
  logic [2:0]             bitPatternIndex;
  logic                   streamSyncOf;
  logic                   regCtrlRunClr;

  modport master (
    output regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
    input  state, bufferAddr, pixelBitIndex, channelIndex, bitPatternIndex,
           streamSyncOf, regCtrlRunClr
  );

  modport slave (
    input  regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
    output state, bufferAddr, pixelBitIndex, channelIndex, bitPatternIndex,
           streamSyncOf, regCtrlRunClr
  );
endinterface

// File: rtl/anton_neopixel_sequencer.sv
// Walks pixel -> channel -> bit -> pattern slot at 6.4 MHz, drives the pixel buffer
// address and inserts the latch period before (and, when looping, between) frames.
module anton_neopixel_sequencer #(
  parameter int BUFFER_END  = 255,
  parameter int RESET_DELAY = 400
) (
  input logic                       clk6_4mhz,
  input logic                       syncRst,
  anton_neopixel_sequencer_if.slave bus
);
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
  localparam int CNT_W       = $clog2(RESET_DELAY);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_LATCH    = 2'b01;
  localparam logic [1:0] ST_TRANSMIT = 2'b10;

  localparam logic [CNT_W-1:0]       CNT_LAST    = CNT_W'(RESET_DELAY - 1);
  localparam logic [BUFFER_BITS-1:0] LAST_PIX_8  = BUFFER_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] LAST_PIX_32 = BUFFER_BITS'((BUFFER_END - 2) / 4);

  logic [1:0]             fsm;
  logic [CNT_W-1:0]       resetCnt;
  logic                   firstLatch;
  logic [BUFFER_BITS-1:0] pixel;
  logic [BUFFER_BITS-1:0] nextPixel;
  logic [1:0]             nextChannel;
  logic                   lastPixel;
  logic                   channelEnd;
  logic                   frameEnd;

  function automatic logic [BUFFER_BITS-1:0] addrOf(input logic [BUFFER_BITS-1:0] pix,
                                                    input logic [1:0]             ch,
                                                    input logic                   wide);
    return wide ? BUFFER_BITS'({pix, ch}) : pix;
  endfunction

  // Last pixel is whichever comes first: regMax or the end of the buffer.
  always_comb begin
    lastPixel   = (pixel >= bus.regMax) ||
                  (pixel >= (bus.regCtrl32bit ? LAST_PIX_32 : LAST_PIX_8));
    channelEnd  = (bus.bitPatternIndex == 3'd7) && (bus.pixelBitIndex == 3'd7);
    frameEnd    = channelEnd && (bus.channelIndex == 2'd2) && lastPixel;
    nextPixel   = pixel;
    nextChannel = bus.channelIndex;
    if (channelEnd) begin
      if (bus.channelIndex == 2'd2) begin
        nextChannel = 2'd0;
        nextPixel   = frameEnd ? '0 : pixel + BUFFER_BITS'(1);
      end else begin
        nextChannel = bus.channelIndex + 2'd1;
      end
    end
  end

  assign bus.state = fsm[1];

  always_ff @(posedge clk6_4mhz) begin
    bus.streamSyncOf  <= 1'b0;
    bus.regCtrlRunClr <= 1'b0;
    if (syncRst || !bus.regCtrlRun) begin
      fsm                 <= ST_IDLE;
      resetCnt            <= '0;
      firstLatch          <= 1'b0;
      pixel               <= '0;
      bus.bufferAddr      <= '0;
      bus.pixelBitIndex   <= '0;
      bus.channelIndex    <= '0;
      bus.bitPatternIndex <= '0;
    end else begin
      case (fsm)
        // Hold off one cycle while our own clear request is still visible.
        ST_IDLE: begin
          if (!bus.regCtrlRunClr) begin
            fsm        <= ST_LATCH;
            resetCnt   <= '0;
            firstLatch <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (resetCnt >= CNT_LAST) begin
            resetCnt         <= '0;
            bus.streamSyncOf <= 1'b1;
            if (bus.regCtrlLoop || firstLatch) begin
              fsm        <= ST_TRANSMIT;
              firstLatch <= 1'b0;
            end else begin
              bus.regCtrlRunClr <= 1'b1;
              fsm               <= ST_IDLE;
            end
          end else begin
            resetCnt <= resetCnt + CNT_W'(1);
          end
        end
        ST_TRANSMIT: begin
          bus.bitPatternIndex <= bus.bitPatternIndex + 3'd1;
          if (bus.bitPatternIndex == 3'd7)
            bus.pixelBitIndex <= bus.pixelBitIndex + 3'd1;
          pixel            <= nextPixel;
          bus.channelIndex <= nextChannel;
          bus.bufferAddr   <= addrOf(nextPixel, nextChannel, bus.regCtrl32bit);
          if (frameEnd)
            fsm <= ST_LATCH;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Bench for anton_neopixel_sequencer: per-cycle reference model plus table-driven
// frame measurements and hand-written corner-case sequences.
module tb_anton_neopixel_sequencer;
  localparam int BE_A = 255;
  localparam int BB_A = $clog2(BE_A + 1);
  localparam int BE_B = 7;
  localparam int BB_B = $clog2(BE_B + 1);
  localparam int RD   = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  anton_neopixel_sequencer_if #(.BUFFER_BITS(BB_A)) busA ();
  anton_neopixel_sequencer_if #(.BUFFER_BITS(BB_B)) busB ();

  anton_neopixel_sequencer #(.BUFFER_END(BE_A), .RESET_DELAY(RD)) dutA (
    .clk6_4mhz(clk), .syncRst(rst), .bus(busA));
  anton_neopixel_sequencer #(.BUFFER_END(BE_B), .RESET_DELAY(RD)) dutB (
    .clk6_4mhz(clk), .syncRst(rst), .bus(busB));

  int checks   = 0;
  int failures = 0;

  bit mActive = 1'b0;
  bit mClr    = 1'b0;
  int mT      = 0;
  int txAddr[$];

  typedef struct {
    bit m32;
    int mx;
    int expTx;
    int expMaxAddr;
  } frameVec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pack(int st, int sy, int cl, int ch, int bi, int sl, int ad);
    return (st << 20) | (sy << 19) | (cl << 18) | (ch << 16) | (bi << 13) | (sl << 10) | ad;
  endfunction

  function automatic int effLast(bit m32, int mx);
    int lim;
    lim = m32 ? (BE_A - 2) / 4 : BE_A;
    return (mx < lim) ? mx : lim;
  endfunction

  // k = cycle number within the transmit phase of a frame
  function automatic int txVec(bit m32, int k, int sy);
    int px, ch;
    px = k / 192;
    ch = (k / 64) % 3;
    return pack(1, sy, 0, ch, (k / 8) % 8, k % 8, m32 ? px * 4 + ch : px);
  endfunction

  task automatic cycle();
    bit r, run, lp, m32, prevClr;
    int mx, f, u, expv, actv;
    r   = rst;
    run = busA.regCtrlRun;
    lp  = busA.regCtrlLoop;
    m32 = busA.regCtrl32bit;
    mx  = int'(busA.regMax);
    @(posedge clk);
    #1;
    prevClr = mClr;
    mClr    = 1'b0;
    expv    = 0;
    if (r || !run) mActive = 1'b0;
    else if (mActive) mT++;
    else if (!prevClr) begin
      mActive = 1'b1;
      mT      = 0;
    end
    if (mActive) begin
      f = (effLast(m32, mx) + 1) * 192;
      if (lp) begin
        u = mT % (RD + f);
        if (u >= RD) expv = txVec(m32, u - RD, int'(u == RD));
      end else if (mT >= RD && mT < RD + f) begin
        expv = txVec(m32, mT - RD, int'(mT == RD));
      end else if (mT == 2 * RD + f) begin
        expv    = pack(0, 1, 1, 0, 0, 0, 0);
        mActive = 1'b0;
        mClr    = 1'b1;
      end
    end
    actv = pack(int'(busA.state), int'(busA.streamSyncOf), int'(busA.regCtrlRunClr),
                int'(busA.channelIndex), int'(busA.pixelBitIndex),
                int'(busA.bitPatternIndex), int'(busA.bufferAddr));
    check("outputs_vs_model", actv, expv);
  endtask

  task automatic measureFrame(input int budget, output int pre, output int tx, output int post,
                              output int clr, output int sync, output int maxAd);
    int phase;
    bit done;
    pre = 0; tx = 0; post = 0; clr = 0; sync = 0; maxAd = 0; phase = 0; done = 1'b0;
    txAddr.delete();
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (busA.regCtrlRunClr) clr++;
      if (busA.streamSyncOf) sync++;
      if (busA.state) begin
        tx++;
        phase = 1;
        txAddr.push_back(int'(busA.bufferAddr));
        if (int'(busA.bufferAddr) > maxAd) maxAd = int'(busA.bufferAddr);
      end else if (busA.regCtrlRunClr) begin
        busA.regCtrlRun = 1'b0;
        done = 1'b1;
        break;
      end else if (phase == 0) pre++;
      else post++;
    end
    check("frame_completed", int'(done), 1);
  endtask

  initial begin
    frameVec_t vecs[5];
    int pre, tx, post, clr, sync, maxAd, cnt, cnt2;
    bit found;
    int seq[9];

    vecs[0] = '{m32: 1'b0, mx: 1, expTx: 384, expMaxAddr: 1};
    vecs[1] = '{m32: 1'b1, mx: 2, expTx: 576, expMaxAddr: 10};
    vecs[2] = '{m32: 1'b0, mx: 0, expTx: 192, expMaxAddr: 0};
    vecs[3] = '{m32: 1'b1, mx: 3, expTx: 768, expMaxAddr: 14};
    vecs[4] = '{m32: 1'b0, mx: 4, expTx: 960, expMaxAddr: 4};
    seq = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    rst = 1'b1;
    busA.regCtrlRun = 1'b1; busA.regCtrlLoop = 1'b0; busA.regCtrl32bit = 1'b0; busA.regMax = 1;
    busB.regCtrlRun = 1'b0; busB.regCtrlLoop = 1'b0; busB.regCtrl32bit = 1'b0; busB.regMax = 0;

    // Reset with Run held high
    repeat (2) cycle();
    check("rst_state", int'(busA.state), 0);
    check("rst_addr", int'(busA.bufferAddr), 0);
    check("rst_slot", int'(busA.bitPatternIndex), 0);
    check("rst_bit", int'(busA.pixelBitIndex), 0);
    check("rst_channel", int'(busA.channelIndex), 0);
    check("rst_sync", int'(busA.streamSyncOf), 0);
    check("rst_clr", int'(busA.regCtrlRunClr), 0);
    rst = 1'b0;

    // Single frames, one per table row
    for (int r = 0; r < 5; r++) begin
      busA.regCtrl32bit = vecs[r].m32;
      busA.regMax       = BB_A'(vecs[r].mx);
      busA.regCtrlLoop  = 1'b0;
      busA.regCtrlRun   = 1'b1;
      measureFrame(3000, pre, tx, post, clr, sync, maxAd);
      check("frame_pre_latch", pre, RD);
      check("frame_tx_cycles", tx, vecs[r].expTx);
      check("frame_post_latch", post, RD);
      check("frame_clr_pulses", clr, 1);
      check("frame_sync_pulses", sync, 2);
      check("frame_max_addr", maxAd, vecs[r].expMaxAddr);
      if (r == 0 && txAddr.size() >= 384) begin
        check("addr8_before_change", txAddr[191], 0);
        check("addr8_after_change", txAddr[192], 1);
      end
      if (r == 1 && txAddr.size() >= 576) begin
        for (int j = 0; j < 9; j++) begin
          check("addr32_first", txAddr[j * 64], seq[j]);
          check("addr32_last", txAddr[j * 64 + 63], seq[j]);
        end
      end
      repeat (3) cycle();
    end

    // Looping with a single pixel
    busA.regCtrlLoop = 1'b1; busA.regCtrl32bit = 1'b0; busA.regMax = 0; busA.regCtrlRun = 1'b1;
    cnt = 0; cnt2 = 0; clr = 0;
    for (int i = 0; i < RD + 3 * (RD + 192); i++) begin
      cycle();
      if (busA.state) cnt++;
      if (busA.streamSyncOf) cnt2++;
      if (busA.regCtrlRunClr) clr++;
    end
    check("loop_tx_cycles", cnt, 3 * 192);
    check("loop_sync_pulses", cnt2, 3);
    check("loop_clr_pulses", clr, 0);
    busA.regCtrlRun = 1'b0; busA.regCtrlLoop = 1'b0;
    repeat (2) cycle();

    // Run dropped mid-frame at slot 3 of pixel 1
    busA.regMax = 3; busA.regCtrlRun = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (busA.state && busA.bufferAddr == 1 && busA.bitPatternIndex == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_point_reached", int'(found), 1);
    busA.regCtrlRun = 1'b0;
    cycle();
    check("abort_state", int'(busA.state), 0);
    check("abort_addr", int'(busA.bufferAddr), 0);
    check("abort_slot", int'(busA.bitPatternIndex), 0);
    check("abort_bit", int'(busA.pixelBitIndex), 0);
    check("abort_channel", int'(busA.channelIndex), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      cnt += int'(busA.streamSyncOf) + int'(busA.regCtrlRunClr);
    end
    check("abort_no_pulses", cnt, 0);
    busA.regCtrlRun = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (busA.state) begin
        found = 1'b1;
        break;
      end
      cnt++;
    end
    check("restart_tx_seen", int'(found), 1);
    check("restart_latch_len", cnt, RD);
    busA.regCtrlRun = 1'b0;
    repeat (2) cycle();

    // Small buffer clips the frame in 32-bit mode
    busB.regCtrl32bit = 1'b1; busB.regMax = 5; busB.regCtrlLoop = 1'b0; busB.regCtrlRun = 1'b1;
    cnt = 0; maxAd = 0; found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (busB.state) begin
        cnt++;
        if (int'(busB.bufferAddr) > maxAd) maxAd = int'(busB.bufferAddr);
      end
      if (busB.regCtrlRunClr) begin
        busB.regCtrlRun = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("clip_frame_done", int'(found), 1);
    check("clip_tx_cycles", cnt, 2 * 192);
    check("clip_max_addr", maxAd, 6);
    repeat (2) cycle();

    // Randomised runs against the model
    for (int n = 0; n < 8; n++) begin
      int len;
      busA.regCtrl32bit = 1'($urandom_range(0, 1));
      busA.regCtrlLoop  = 1'($urandom_range(0, 1));
      busA.regMax       = BB_A'($urandom_range(0, 4));
      busA.regCtrlRun   = 1'b1;
      len = int'($urandom_range(300, 2600));
      for (int i = 0; i < len; i++) begin
        rst = (n == 3 && i == len / 2);
        cycle();
        if (busA.regCtrlRunClr) busA.regCtrlRun = 1'b0;
      end
      rst = 1'b0;
      busA.regCtrlRun = 1'b0;
      repeat (3) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
